// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle execute-stage ALU.
// Holds the ALU operation encodings (names kept identical to the old
// ALU_* defines), the controller state type and opcode classifier helpers.
package alu_multicycle_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_SLTU  = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_NOR   = 4'd7;
  localparam logic [3:0] ALU_MULTU = 4'd8;
  localparam logic [3:0] ALU_DIVU  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // True for the operations served by the iterative multiply/divide unit.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

  // Codes above DIVU have no meaning and are reported through bad_op.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit
// per cycle, WIDTH cycles per operation.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts operation)
//   start         load operands and begin (ignored effect while busy)
//   is_div        1 = divide, 0 = multiply; captured on start
//   op_a, op_b    multiplicand/dividend and multiplier/divisor
//   done          high during the cycle whose step is the final one
//   lo_next       value the low register takes at the end of this cycle
//                 (product low half / quotient once done is high)
//   hi_next       same for the high register (product high / remainder)
module alu_muldiv_iter
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  // hi/lo form one 2*WIDTH shift register: {acc, multiplier} when
  // multiplying, {remainder, dividend/quotient} when dividing.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;

  // One iteration step plus operand load.
  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    div_d   = div_q;
    add_s   = {1'b0, hi_q} + {1'b0, b_q};
    trial_s = {hi_q, lo_q[WIDTH-1]};
    diff_s  = trial_s - {1'b0, b_q};
    if (start) begin
      cnt_d = CNT_W'(WIDTH);
      hi_d  = {WIDTH{1'b0}};
      lo_d  = op_a;
      b_d   = op_b;
      div_d = is_div;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        // A zero divisor always "fits": quotient fills with ones and the
        // dividend shifts unchanged into the remainder.
        if (trial_s >= {1'b0, b_q}) begin
          hi_d = diff_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = trial_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Carry out of the add becomes the new top bit after the shift.
        if (lo_q[0]) begin
          hi_d = add_s[WIDTH:1];
          lo_d = {add_s[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  assign done    = (cnt_q == CNT_W'(1));
  assign lo_next = lo_d;
  assign hi_next = hi_d;

  // Datapath and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
      hi_q  <= {WIDTH{1'b0}};
      lo_q  <= {WIDTH{1'b0}};
      b_q   <= {WIDTH{1'b0}};
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked execute-stage ALU with single-cycle logic/arithmetic ops and
// iterative MULTU/DIVU producing a HI/LO pair.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; accept = in_valid & in_ready
//   alu_op, in1, in2    operation and operands, captured on accept
//   out_valid/out_ready result handshake; outputs held until out_ready
//   result, result_hi   LO/primary result and HI (product high/remainder)
//   zero, overflow      result==0, signed overflow for ADD/SUB
//   bad_op              opcode outside the defined set
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             bad_op
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             bad_op_q, bad_op_d;
  logic             out_valid_q, out_valid_d;

  logic             accept_s;
  logic             mdu_start_s;
  logic             mdu_done_s;
  logic [WIDTH-1:0] mdu_lo_s;
  logic [WIDTH-1:0] mdu_hi_s;

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] sc_result_s;
  logic             sc_ovf_s;

  assign in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept_s    = in_valid & in_ready;
  assign mdu_start_s = accept_s & is_multicycle(alu_op);

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (mdu_start_s),
    .is_div  (alu_op == ALU_DIVU),
    .op_a    (in1),
    .op_b    (in2),
    .done    (mdu_done_s),
    .lo_next (mdu_lo_s),
    .hi_next (mdu_hi_s)
  );

  assign sum_s  = in1 + in2;
  assign diff_s = in1 - in2;

  // Single-cycle result and overflow for the current request.
  always_comb begin
    sc_result_s = {WIDTH{1'b0}};
    sc_ovf_s    = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        sc_result_s = sum_s;
        sc_ovf_s    = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_s[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_result_s = diff_s;
        sc_ovf_s    = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_s[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_AND:  sc_result_s = in1 & in2;
      ALU_OR:   sc_result_s = in1 | in2;
      ALU_SLT:  sc_result_s = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_SLTU: sc_result_s = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      ALU_XOR:  sc_result_s = in1 ^ in2;
      ALU_NOR:  sc_result_s = ~(in1 | in2);
      default: begin
        sc_result_s = {WIDTH{1'b0}};
        sc_ovf_s    = 1'b0;
      end
    endcase
  end

  // Controller next state and next output register values.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    bad_op_d    = bad_op_q;
    out_valid_d = out_valid_q;
    if (accept_s) begin
      // Accept is only possible from IDLE or a DONE being drained, which
      // covers the back-to-back case.
      if (is_multicycle(alu_op)) begin
        state_d     = ST_BUSY;
        out_valid_d = 1'b0;
      end else begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        result_d    = sc_result_s;
        result_hi_d = {WIDTH{1'b0}};
        zero_d      = (sc_result_s == {WIDTH{1'b0}});
        overflow_d  = sc_ovf_s;
        bad_op_d    = !is_legal_op(alu_op);
      end
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (mdu_done_s) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = mdu_lo_s;
            result_hi_d = mdu_hi_s;
            zero_d      = (mdu_lo_s == {WIDTH{1'b0}});
            overflow_d  = 1'b0;
            bad_op_d    = 1'b0;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      bad_op_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      bad_op_q    <= bad_op_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign bad_op    = bad_op_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases,
// randomized operations against an arithmetic reference model,
// backpressure, back-to-back accept, mid-operation reset and illegal ops.
module tb_alu_multicycle;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;
  logic        bad_op;

  int total_cnt = 0;
  int bad_cnt   = 0;

  alu_multicycle dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .overflow  (overflow),
    .bad_op    (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the operation definitions, using wide integers.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic z, output logic ov, output logic bad);
    longint sa;
    longint sb;
    longint sr;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lo  = 32'd0;
    hi  = 32'd0;
    ov  = 1'b0;
    bad = 1'b0;
    case (op)
      4'd0: begin sr = sa + sb; lo = a + b; ov = (sr > SMAX) || (sr < SMIN); end
      4'd1: begin sr = sa - sb; lo = a - b; ov = (sr > SMAX) || (sr < SMIN); end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: lo = (a < b) ? 32'd1 : 32'd0;
      4'd6: lo = a ^ b;
      4'd7: lo = ~(a | b);
      4'd8: begin p = {32'd0, a} * {32'd0, b}; lo = p[31:0]; hi = p[63:32]; end
      4'd9: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: bad = 1'b1;
    endcase
    z = (lo == 32'd0);
  endfunction

  // Issue one operation with out_ready=1 and check latency and all outputs.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_lo, e_hi;
    logic        e_z, e_ov, e_bad;
    int          lat, wait_n, busy_rdy, exp_lat;
    model(op, a, b, e_lo, e_hi, e_z, e_ov, e_bad);
    exp_lat = (op == 4'd8 || op == 4'd9) ? 33 : 1;
    @(negedge clk);
    alu_op = op; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble inputs: the operation in flight must not see them.
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; alu_op = 4'($urandom_range(0, 15));
    lat = 0; busy_rdy = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) busy_rdy++;
    end
    check_val($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
    check_val($sformatf("busy_in_ready op%0d", op), 64'(busy_rdy), 64'd0);
    check_val($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(result), 64'(e_lo));
    check_val($sformatf("result_hi op%0d", op), 64'(result_hi), 64'(e_hi));
    check_val($sformatf("zero op%0d", op), 64'(zero), 64'(e_z));
    check_val($sformatf("overflow op%0d", op), 64'(overflow), 64'(e_ov));
    check_val($sformatf("bad_op op%0d", op), 64'(bad_op), 64'(e_bad));
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; } vec_t;

  vec_t        dir_q[$];
  logic [31:0] corner[6];
  logic [31:0] ra, rb;
  int          pulses;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 4'd0; in1 = 32'd0; in2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_result", 64'(result), 64'd0);
    check_val("rst_result_hi", 64'(result_hi), 64'd0);
    check_val("rst_flags", 64'({zero, overflow, bad_op}), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);

    dir_q.push_back('{4'd0, 32'd5, 32'd10});
    dir_q.push_back('{4'd0, 32'd9, 32'hFFFF_FFF7});
    dir_q.push_back('{4'd1, 32'd5, 32'd10});
    dir_q.push_back('{4'd4, 32'hFFFF_FFFF, 32'd1});
    dir_q.push_back('{4'd5, 32'hFFFF_FFFF, 32'd1});
    dir_q.push_back('{4'd0, 32'h7FFF_FFFF, 32'd1});
    dir_q.push_back('{4'd1, 32'h8000_0000, 32'd1});
    dir_q.push_back('{4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    dir_q.push_back('{4'd9, 32'd100, 32'd7});
    dir_q.push_back('{4'd9, 32'd123, 32'd0});
    dir_q.push_back('{4'd12, 32'd77, 32'd3});
    dir_q.push_back('{4'd7, 32'hFFFF_0000, 32'h0000_FFFF});
    foreach (dir_q[i]) run_op(dir_q[i].op, dir_q[i].a, dir_q[i].b);

    // Backpressure: hold the AND result, then drain with a same-cycle accept.
    @(negedge clk);
    alu_op = 4'd2; in1 = 32'h0000_F0F0; in2 = 32'h0000_FF00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'd1);
      check_val($sformatf("bp_result_%0d", k), 64'(result), 64'h0000_F000);
    end
    alu_op = 4'd3; in1 = 32'd1; in2 = 32'd0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_val("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("b2b_valid", 64'(out_valid), 64'd1);
    check_val("b2b_result", 64'(result), 64'd1);

    // Reset 10 cycles into a multiply: no result may ever appear.
    @(negedge clk);
    alu_op = 4'd8; in1 = 32'd12345; in2 = 32'd678; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_in_ready", 64'(in_ready), 64'd1);
    check_val("abort_result", 64'(result), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check_val("abort_pulses", 64'(pulses), 64'd0);
    run_op(4'd0, 32'd1, 32'd1);

    // Randomized operations with corner-biased operands.
    corner[0] = 32'd0;          corner[1] = 32'd1;
    corner[2] = 32'hFFFF_FFFF;  corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;  corner[5] = 32'h0000_FFFF;
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      run_op(4'($urandom_range(0, 15)), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, handshaked successor to the combinational execute-stage ALU of the pipelined MIPS core.
- Adds width generalisation, unsigned and logical ops, status flags, and iterative multiply/divide producing a HI/LO pair.
- Sits in EX; the hazard unit stalls the pipeline while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- alu_op  in  4  operation code
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  LO / primary result
- result_hi  out  WIDTH  upper product or remainder; 0 for single-cycle ops
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- bad_op  out  1  alu_op not in the encoding list

Behaviour:
- Encodings: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLTU=5, XOR=6, NOR=7, MULTU=8, DIVU=9. Codes 10–15 are illegal.
- FSM states IDLE, BUSY, DONE. Reset enters IDLE and clears every output: result, result_hi, flags, out_valid=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept fires when in_valid & in_ready. Operands and op are captured on accept.
- Single-cycle ops (0–7) and illegal ops go accept -> DONE. out_valid is high the next cycle (latency 1).
- Single-cycle arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - overflow = operand signs equal (ADD) or different (SUB) and result sign differs from in1.
  - SLT compares signed; SLTU compares unsigned. Both return 0 or 1 zero-extended.
- MULTU: shift-add, one bit per cycle. Accept -> BUSY for exactly WIDTH cycles -> DONE.
  - Latency WIDTH+1 from accept to out_valid.
  - {result_hi,result} = full 2*WIDTH-bit unsigned product.
- DIVU: restoring divide, same WIDTH-cycle timing. result = quotient, result_hi = remainder.
  - Divide by zero: quotient = all ones, remainder = in1. Latency is unchanged and no flag is raised.
- Illegal op: result=0, result_hi=0, bad_op=1, zero=1.
- DONE: outputs are stable until out_ready. DONE & out_ready & !accept -> IDLE. DONE & out_ready & accept -> next op starts (back-to-back).
- In BUSY, in_valid is ignored and in_ready=0. Changes on in1/in2/alu_op do not affect the operation in flight.
- out_valid is low in IDLE and BUSY. zero/overflow/bad_op are valid only while out_valid=1 and are held with result.
- rst during BUSY or DONE: the operation is aborted, the FSM returns to IDLE next edge, outputs are cleared, and no out_valid pulse occurs.
- The counter loads WIDTH on accept of MULTU/DIVU and decrements in BUSY. BUSY -> DONE when the counter reaches 1 and the last step completes.

Decomposition:
- Shared package/header holds:
  - ALU op encodings, replacing the existing ALU_* defines with identical names.
  - FSM state typedef.
  - A classifier function is_multicycle(op).
- One sub-module: alu_muldiv_iter. It is the WIDTH-cycle shift-add/restoring datapath with start/done and an internal counter.
- The top holds the FSM, single-cycle combinational ops, flags and output registers.

Test Plan:
- Single-cycle ops, WIDTH=32, out_ready=1:
  - ADD 5,10 -> result 0x0000000F one cycle after accept; zero=0.
  - ADD 9,0xFFFFFFF7 -> 0, zero=1.
  - SUB 5,10 -> 0xFFFFFFFB.
  - SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
- Overflow: ADD 0x7FFFFFFF,1 -> result 0x80000000, overflow=1. SUB 0x80000000,1 -> 0x7FFFFFFF, overflow=1.
- MULTU 0xFFFFFFFF,0xFFFFFFFF -> result_hi 0xFFFFFFFE, result 0x00000001.
  - out_valid rises exactly 33 cycles after accept; in_ready=0 throughout BUSY.
- DIVU:
  - 100,7 -> quotient 14, remainder 2.
  - 123,0 -> quotient 0xFFFFFFFF, remainder 123.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after an AND 0xF0F0,0xFF00 -> result 0xF000 held stable, out_valid stays high.
  - Then out_ready=1 with in_valid=1 OR 1,0 -> accepted the same cycle, next result 1.
- Reset/illegal:
  - Assert rst 10 cycles into MULTU -> out_valid never pulses, in_ready=1 after reset; the following ADD 1,1 returns 2.
  - alu_op=12 -> bad_op=1, result 0.
